// File: rtl/oclib_pkg.sv
// oclib_pkg: shared channel types for the oclib blocks
package oclib_pkg;
  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       ready;
  } bc_8b_bidi_s;
endpackage

// File: rtl/oclib_uart_pkg.sv
// oclib_uart_pkg: UART error-bit layout and FSM state encodings
package oclib_uart_pkg;
  localparam int ErrorWidth   = 3;
  localparam int ErrorFraming = 0;
  localparam int ErrorOverrun = 1;
  localparam int ErrorBreak   = 2;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rxState_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} txState_e;
endpackage

// File: rtl/oc_uart_bc_bridge_fifo.sv
// oc_uart_bc_bridge_fifo: depth x 8-bit synchronous FIFO, pushes when full and pops when empty are ignored
module oc_uart_bc_bridge_fifo #(
  parameter int Depth = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] pushData,
  input  logic       pop,
  output logic [7:0] popData,
  output logic       empty,
  output logic       full
);
  localparam int Aw = $clog2(Depth);
  logic [7:0] mem [Depth];
  logic [Aw-1:0] wrPtr, rdPtr;
  logic [Aw:0] count;
  logic doPush, doPop;
  assign empty = count == '0;
  assign full = count == (Aw+1)'(Depth);
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  assign popData = mem[rdPtr];
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + Aw'(doPush);
      rdPtr <= rdPtr + Aw'(doPop);
      count <= count + (Aw+1)'(doPush) - (Aw+1)'(doPop);
    end
  end
endmodule

// File: rtl/oc_uart_bc_bridge.sv
// oc_uart_bc_bridge: UART pin pair to 8-bit bidirectional byte channel,
// with sticky line errors and a break-triggered reset request
module oc_uart_bc_bridge
  import oclib_pkg::*;
  import oclib_uart_pkg::*;
#(
  parameter int ClockHz          = 100_000_000,
  parameter int Baud             = 115200,
  parameter int RxFifoDepth      = 4,
  parameter int TxFifoDepth      = 4,
  parameter int BreakResetEnable = 1,
  parameter int BreakBits        = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  uartRx,
  output logic                  uartTx,
  output bc_8b_bidi_s           bcOut,
  input  bc_8b_bidi_s           bcIn,
  output logic                  resetOut,
  output logic [ErrorWidth-1:0] uartError
);
  localparam int RawCycles = (ClockHz + Baud / 2) / Baud;
  localparam int CyclesPerBit = RawCycles < 4 ? 4 : RawCycles;
  localparam int BreakCycles = BreakBits * CyclesPerBit;
  localparam int CntW = $clog2(CyclesPerBit);
  localparam int LowW = $clog2(BreakCycles + 1);
  localparam logic [CntW-1:0] BitEnd = CntW'(CyclesPerBit - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CyclesPerBit / 2 - 1);
  localparam logic [LowW-1:0] LowMax = LowW'(BreakCycles);
  localparam logic [LowW-1:0] LowEnd = LowW'(BreakCycles - 1);
  logic rxMeta, rxSync, rxPrev, rxPush, rxEmpty, rxFull;
  logic [7:0] rxShift, rxHead;
  logic [2:0] rxBit;
  logic [CntW-1:0] rxCnt;
  logic [LowW-1:0] lowCnt;
  rxState_e rxState;
  logic txEmpty, txFull, txLoad;
  logic [7:0] txShift, txHead;
  logic [2:0] txBit;
  logic [CntW-1:0] txCnt;
  txState_e txState;
  assign bcOut = '{data: rxHead, valid: !rxEmpty, ready: !txFull};
  oc_uart_bc_bridge_fifo #(.Depth(RxFifoDepth)) rxFifo (
    .clock(clock), .reset(reset), .push(rxPush), .pushData(rxShift),
    .pop(bcIn.ready), .popData(rxHead), .empty(rxEmpty), .full(rxFull)
  );
  oc_uart_bc_bridge_fifo #(.Depth(TxFifoDepth)) txFifo (
    .clock(clock), .reset(reset), .push(bcIn.valid), .pushData(bcIn.data),
    .pop(txLoad), .popData(txHead), .empty(txEmpty), .full(txFull)
  );
  // rxShift holds the finished byte for the cycle after the stop sample, when the FIFO write lands
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
      rxState <= RxIdle;
      rxCnt <= '0;
      rxBit <= '0;
      rxShift <= '0;
      rxPush <= 1'b0;
      lowCnt <= '0;
      resetOut <= 1'b0;
      uartError <= '0;
    end else begin
      rxMeta <= uartRx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
      rxPush <= 1'b0;
      resetOut <= 1'b0;
      lowCnt <= rxSync ? '0 : lowCnt + LowW'(lowCnt != LowMax);
      if (rxPush && rxFull) uartError[ErrorOverrun] <= 1'b1;
      if (!rxSync && lowCnt == LowEnd) begin
        rxState <= RxBreak;
        uartError[ErrorBreak] <= 1'b1;
        resetOut <= BreakResetEnable != 0;
      end else begin
        case (rxState)
          RxIdle: begin
            if (rxPrev && !rxSync) begin
              rxState <= RxStart;
              rxCnt <= CntW'(1);
            end
          end
          RxStart: begin
            rxCnt <= rxCnt == HalfEnd ? '0 : rxCnt + 1'b1;
            rxBit <= '0;
            if (rxCnt == HalfEnd) rxState <= rxSync ? RxIdle : RxData;
          end
          RxData: begin
            rxCnt <= rxCnt == BitEnd ? '0 : rxCnt + 1'b1;
            if (rxCnt == BitEnd) begin
              rxShift <= {rxSync, rxShift[7:1]};
              rxBit <= rxBit + 3'd1;
              if (rxBit == 3'd7) rxState <= RxStop;
            end
          end
          RxStop: begin
            rxCnt <= rxCnt == BitEnd ? '0 : rxCnt + 1'b1;
            if (rxCnt == BitEnd) begin
              rxState <= RxIdle;
              rxPush <= rxSync;
              if (!rxSync) uartError[ErrorFraming] <= 1'b1;
            end
          end
          RxBreak: if (rxSync) rxState <= RxIdle;
          default: rxState <= RxIdle;
        endcase
      end
    end
  end
  // reloading at the end of STOP keeps back-to-back frames gapless
  assign txLoad = !txEmpty && (txState == TxIdle || (txState == TxStop && txCnt == BitEnd));
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txState <= TxIdle;
      txCnt <= '0;
      txBit <= '0;
      txShift <= '0;
      uartTx <= 1'b1;
    end else if (txLoad) begin
      txState <= TxStart;
      txCnt <= '0;
      txBit <= '0;
      txShift <= txHead;
      uartTx <= 1'b0;
    end else if (txState != TxIdle) begin
      txCnt <= txCnt == BitEnd ? '0 : txCnt + 1'b1;
      if (txCnt == BitEnd) begin
        case (txState)
          TxStart: begin
            txState <= TxData;
            uartTx <= txShift[0];
            txShift <= txShift >> 1;
          end
          TxData: begin
            txBit <= txBit + 3'd1;
            txShift <= txShift >> 1;
            uartTx <= txBit == 3'd7 ? 1'b1 : txShift[0];
            txState <= txBit == 3'd7 ? TxStop : TxData;
          end
          default: txState <= TxIdle;
        endcase
      end
    end
  end
endmodule
